sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO, the next generation of the team's 8x16 put/get FIFO. It supports arbitrary power-of-two depth and any data width. It adds an occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses. It sits between producer and consumer blocks in the same clock domain and uses the same put/get handshake, so existing benches and UVM agents reuse directly.

---
 rtl/sync_fifo_param.sv | 139 +++++++++++++
 tb/tb_sync_fifo_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full / almost-empty flags and registered
// overflow / underflow error pulses.
//
// Build option:
//   SYNC_FIFO_FWFT_EN  defined   -> first-word fall-through. data_out shows
//                                   the head word combinationally; 0 when empty.
//   SYNC_FIFO_FWFT_EN  undefined -> registered read. data_out updates on the
//                                   edge that accepts a get and holds otherwise.
//
// Handshake: put and get are requests sampled on the rising edge of clk.
// A put is accepted when the FIFO is not full and a get is accepted when
// the FIFO is not empty, both judged on the state before that edge.
// Rejected requests leave pointers and memory untouched. Each rejection
// raises overflow/underflow for the single cycle after the edge.
// reset takes priority over any put/get on the same edge.

module sync_fifo_param #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 16,
    parameter int PTR_W    = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             put,
    input  logic             get,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty_bar,
    output logic             full_bar,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    output logic             underflow
);

    // Reject parameter sets that would silently break pointer arithmetic
    // or make a threshold flag unreachable.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 2");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
            $fatal(1, "sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
        end
        if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
            $fatal(1, "sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
        end
    endgenerate

    // Thresholds sized to the count width so comparisons stay width-matched.
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] AF_C    = (PTR_W + 1)'(AF_LEVEL);
    localparam logic [PTR_W:0] AE_C    = (PTR_W + 1)'(AE_LEVEL);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0] PTR_ZERO = '0;

    // Storage and pointers. The pointer MSB is the wrap bit, so
    // wr_ptr - rd_ptr (mod 2^(PTR_W+1)) spans the full 0..DEPTH range.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   occupancy;
    logic [PTR_W-1:0] wr_addr;
    logic [PTR_W-1:0] rd_addr;
    logic             full;
    logic             empty;
    logic             put_e;
    logic             get_e;

    assign occupancy = wr_ptr - rd_ptr;
    assign full      = (occupancy == DEPTH_C);
    assign empty     = (occupancy == PTR_ZERO);
    assign wr_addr   = wr_ptr[PTR_W-1:0];
    assign rd_addr   = rd_ptr[PTR_W-1:0];

    // Accepted transfers; reset blocks both so nothing is written or popped.
    assign put_e = put & ~full & ~reset;
    assign get_e = get & ~empty & ~reset;

    // Status outputs depend only on the registered pointers.
    assign count        = occupancy;
    assign empty_bar    = ~empty;
    assign full_bar     = ~full;
    assign almost_full  = (occupancy >= AF_C);
    assign almost_empty = (occupancy <= AE_C);

    // Advance the pointers on accepted transfers; reset discards all data.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= PTR_ZERO;
            rd_ptr <= PTR_ZERO;
        end else begin
            if (put_e) wr_ptr <= wr_ptr + PTR_ONE;
            if (get_e) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Write the accepted word; memory is intentionally not cleared on reset.
    always_ff @(posedge clk) begin
        if (put_e) mem[wr_addr] <= data_in;
    end

    // Register one-cycle error pulses for rejected requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= put & full;
            underflow <= get & empty;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Present the head word directly; a get pops the word currently shown.
    always_comb begin
        data_out = '0;
        if (!empty) data_out = mem[rd_addr];
    end
`else
    logic [WIDTH-1:0] data_q;

    // Registered read: capture the head word on the edge that accepts a get.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else if (get_e) begin
            data_q <= mem[rd_addr];
        end
    end

    assign data_out = data_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed scenarios plus randomized traffic for
// sync_fifo_param (DEPTH=8, WIDTH=16), checked against a queue-based
// reference model. Follows SYNC_FIFO_FWFT_EN for the read-data timing.

module tb_sync_fifo_param;

    localparam int DEPTH = 8;
    localparam int WIDTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic             clk;
    logic             reset;
    logic             put;
    logic             get;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             empty_bar;
    logic             full_bar;
    logic             almost_full;
    logic             almost_empty;
    logic [3:0]       count;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_dout;
    logic             exp_ovf;
    logic             exp_udf;

    sync_fifo_param #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .put          (put),
        .get          (get),
        .data_in      (data_in),
        .data_out     (data_out),
        .empty_bar    (empty_bar),
        .full_bar     (full_bar),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected data_out as seen by the consumer in the current build.
    function automatic logic [WIDTH-1:0] exp_data();
`ifdef SYNC_FIFO_FWFT_EN
        return (exp_q.size() != 0) ? exp_q[0] : '0;
`else
        return exp_dout;
`endif
    endfunction

    // Drive one clock of requests and advance the model by the FIFO rules.
    task automatic cycle(input logic p, input logic g, input logic [WIDTH-1:0] d);
        bit was_full;
        bit was_empty;
        logic [WIDTH-1:0] popped;
        put = p;
        get = g;
        data_in = d;
        @(posedge clk);
        was_full  = (exp_q.size() == DEPTH);
        was_empty = (exp_q.size() == 0);
        exp_ovf = p & was_full;
        exp_udf = g & was_empty;
        if (g && !was_empty) begin
            popped = exp_q.pop_front();
            exp_dout = popped;
        end
        if (p && !was_full) exp_q.push_back(d);
        #1;
        put = 1'b0;
        get = 1'b0;
    endtask

    // One reset edge, optionally with requests asserted alongside it.
    task automatic reset_cycle(input logic p, input logic g, input logic [WIDTH-1:0] d);
        reset = 1'b1;
        put = p;
        get = g;
        data_in = d;
        @(posedge clk);
        exp_q.delete();
        exp_dout = '0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        #1;
        reset = 1'b0;
        put = 1'b0;
        get = 1'b0;
    endtask

    task automatic test_reset();
        reset_cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty_bar !== 1'b0) begin errors++; $display("FAIL reset_empty_bar: got %b expected 0", empty_bar); end
        checks++; if (full_bar !== 1'b1) begin errors++; $display("FAIL reset_full_bar: got %b expected 1", full_bar); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b expected 1", almost_empty); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b expected 0", almost_full); end
        checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL reset_data_out: got %h expected 0000", data_out); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_pulses: got ovf=%b udf=%b expected 0 0", overflow, underflow); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, 1'b0, 16'(i));
            checks++; if (count !== 4'(i)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", count, i); end
            checks++; if (almost_full !== (i >= AF)) begin errors++; $display("FAIL fill_almost_full: got %b expected %b at count %0d", almost_full, (i >= AF), i); end
            checks++; if (full_bar !== (i != DEPTH)) begin errors++; $display("FAIL fill_full_bar: got %b expected %b at count %0d", full_bar, (i != DEPTH), i); end
        end
        cycle(1'b1, 1'b0, 16'hDEAD);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_pulse: got %b expected 1", overflow); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL overflow_count: got %0d expected 8", count); end
        cycle(1'b0, 1'b0, '0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_single_cycle: got %b expected 0", overflow); end
    endtask

    task automatic test_drain_underflow();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, 1'b1, '0);
`ifndef SYNC_FIFO_FWFT_EN
            checks++; if (data_out !== 16'(i)) begin errors++; $display("FAIL drain_data: got %h expected %h", data_out, 16'(i)); end
`endif
            checks++; if (data_out !== exp_data()) begin errors++; $display("FAIL drain_model_data: got %h expected %h", data_out, exp_data()); end
            checks++; if (count !== 4'(DEPTH - i)) begin errors++; $display("FAIL drain_count: got %0d expected %0d", count, DEPTH - i); end
        end
        cycle(1'b0, 1'b1, '0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_pulse: got %b expected 1", underflow); end
        checks++; if (data_out !== exp_data()) begin errors++; $display("FAIL underflow_hold: got %h expected %h", data_out, exp_data()); end
        cycle(1'b0, 1'b0, '0);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_single_cycle: got %b expected 0", underflow); end
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, 16'(i));
        cycle(1'b1, 1'b1, 16'h0BAD);
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_pg_count: got %0d expected 7", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_pg_overflow: got %b expected 1", overflow); end
`ifndef SYNC_FIFO_FWFT_EN
        checks++; if (data_out !== 16'h0001) begin errors++; $display("FAIL full_pg_head: got %h expected 0001", data_out); end
`endif
        checks++; if (data_out !== exp_data()) begin errors++; $display("FAIL full_pg_model_data: got %h expected %h", data_out, exp_data()); end
        while (exp_q.size() != 0) cycle(1'b0, 1'b1, '0);
        cycle(1'b1, 1'b1, 16'h00AA);
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL empty_pg_count: got %0d expected 1", count); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL empty_pg_underflow: got %b expected 1", underflow); end
        cycle(1'b0, 1'b1, '0);
        checks++; if (exp_dout !== 16'h00AA || data_out !== exp_data()) begin errors++; $display("FAIL empty_pg_readback: got %h expected %h", data_out, exp_data()); end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] next_val;
        next_val = 16'h0100;
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 5; k++) begin
                cycle(1'b1, 1'b0, next_val);
                next_val = next_val + 16'd1;
                checks++; if (count > 4'd5 || count !== 4'(exp_q.size())) begin errors++; $display("FAIL wrap_count: got %0d expected %0d", count, exp_q.size()); end
            end
            for (int k = 0; k < 5; k++) begin
                cycle(1'b0, 1'b1, '0);
                checks++; if (data_out !== exp_data()) begin errors++; $display("FAIL wrap_data: got %h expected %h round %0d", data_out, exp_data(), r); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'h0500 + 16'(i));
        reset_cycle(1'b1, 1'b0, 16'hBEEF);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL midreset_count: got %0d expected 0", count); end
        checks++; if (empty_bar !== 1'b0) begin errors++; $display("FAIL midreset_empty_bar: got %b expected 0", empty_bar); end
        checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL midreset_data_out: got %h expected 0000", data_out); end
        cycle(1'b1, 1'b0, 16'h1234);
        cycle(1'b0, 1'b1, '0);
        checks++; if (exp_dout !== 16'h1234 || data_out !== exp_data()) begin errors++; $display("FAIL midreset_readback: got %h expected %h", data_out, exp_data()); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL midreset_final_count: got %0d expected 0", count); end
    endtask

    task automatic test_random();
        logic p;
        logic g;
        int   bias;
        for (int n = 0; n < 600; n++) begin
            bias = (n / 100) % 3;
            p = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
            g = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
            cycle(p, g, 16'($urandom));
            checks++; if (count !== 4'(exp_q.size())) begin errors++; $display("FAIL rand_count: got %0d expected %0d cycle %0d", count, exp_q.size(), n); end
            checks++; if (data_out !== exp_data()) begin errors++; $display("FAIL rand_data: got %h expected %h cycle %0d", data_out, exp_data(), n); end
            checks++; if (empty_bar !== (exp_q.size() != 0) || full_bar !== (exp_q.size() != DEPTH)) begin errors++; $display("FAIL rand_flags: got eb=%b fb=%b expected size %0d", empty_bar, full_bar, exp_q.size()); end
            checks++; if (almost_full !== (exp_q.size() >= AF) || almost_empty !== (exp_q.size() <= AE)) begin errors++; $display("FAIL rand_almost: got af=%b ae=%b expected size %0d", almost_full, almost_empty, exp_q.size()); end
            checks++; if (overflow !== exp_ovf || underflow !== exp_udf) begin errors++; $display("FAIL rand_pulses: got ovf=%b udf=%b expected %b %b", overflow, underflow, exp_ovf, exp_udf); end
        end
    endtask

    initial begin
        reset = 1'b1;
        put = 1'b0;
        get = 1'b0;
        data_in = '0;
        exp_dout = '0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
